and8_operand_loader: RTL and testbench

- Upstream feeder for the 8-input bitwise-AND reducer (ports a..h, q).
- Accepts a serial stream of WIDTH-bit words over a valid/ready handshake and packs up to 8 of them into operand registers a..h.
- Presents the packed frame, held stable, to the reducer with an out_valid/out_ready handshake.
- Short frames, terminated by in_last, are padded with all-ones (the AND identity), so the reducer output is unaffected by empty slots.

---
 rtl/and8_operand_loader.sv | 94 +++++++++
 tb/tb_and8_operand_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/and8_operand_loader.sv
// Packs a valid/ready stream of WIDTH-bit words into eight operand slots (a..h)
// for the 8-input AND reducer; short frames are padded with all-ones.
module and8_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [3:0]       n_words,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o_dbg_state
);

  // Handshakes: a beat moves when valid & ready are both high at a rising clk edge.
  // in_ready and out_valid are complementary; the producer may not retract valid.
  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic [3:0]       r_n_words;
  logic [WIDTH-1:0] r_slot [8];
  logic             w_accept;
  logic             w_release;
  logic             w_close;

  assign w_accept  = (r_state == S_FILL) && in_valid;
  assign w_release = (r_state == S_HOLD) && out_ready;
  assign w_close   = w_accept && ((r_cnt == 3'd7) || in_last);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL:  if (w_close)   w_next_state = S_HOLD;
      S_HOLD:  if (w_release) w_next_state = S_FILL;
      default: w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // All-ones is the AND identity, so unwritten slots never affect the reducer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 3'd0;
      r_n_words <= 4'd0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '1;
    end else if (w_accept) begin
      r_slot[r_cnt] <= in_data;
      r_cnt         <= r_cnt + 3'd1;
      r_n_words     <= {1'b0, r_cnt} + 4'd1;
    end else if (w_release) begin
      r_cnt     <= 3'd0;
      r_n_words <= 4'd0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '1;
    end
  end

  assign out_valid   = (r_state == S_HOLD);
  assign in_ready    = ~out_valid;
  assign n_words     = r_n_words;
  assign o_dbg_state = r_state;

  assign a = r_slot[0];
  assign b = r_slot[1];
  assign c = r_slot[2];
  assign d = r_slot[3];
  assign e = r_slot[4];
  assign f = r_slot[5];
  assign g = r_slot[6];
  assign h = r_slot[7];

endmodule

// File: tb/tb_and8_operand_loader.sv
// Directed bench for and8_operand_loader at WIDTH=7 with hand-computed frames.
module tb_and8_operand_loader;
  localparam int W = 7;
  localparam logic [W-1:0] ONES = 7'h7F;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic [3:0]   n_words;
  logic         out_valid;
  logic         out_ready;
  logic         dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;

  and8_operand_loader #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .n_words    (n_words),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: presents one beat for one cycle and records the expected word.
  task automatic send_word(input logic [W-1:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    exp_q.push_back(data);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [3:0] exp_n, input logic [W-1:0] exp_and);
    logic [W-1:0] obs [8];
    logic [W-1:0] want;
    obs = '{a, b, c, d, e, f, g, h};
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " n_words"}, 32'(n_words), 32'(exp_n));
    for (int i = 0; i < 8; i++) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : ONES;
      check($sformatf("%s slot%0d", tag, i), 32'(obs[i]), 32'(want));
    end
    check({tag, " q"}, 32'(a & b & c & d & e & f & g & h), 32'(exp_and));
  endtask

  task automatic check_empty(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " n_words"}, 32'(n_words), 32'd0);
    check({tag, " a..h"}, 32'(a & b & c & d & e & f & g & h), 32'(ONES));
    check({tag, " a"}, 32'(a), 32'(ONES));
    check({tag, " h"}, 32'(h), 32'(ONES));
  endtask

  task automatic release_frame(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_empty(tag);
  endtask

  initial begin
    logic [W-1:0] words8 [8];
    words8 = '{7'h7E, 7'h3F, 7'h7D, 7'h77, 7'h6F, 7'h5F, 7'h7B, 7'h7C};
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    check_empty("reset");
    reset = 1'b0;
    tick();
    tick();
    check_empty("idle");
    check("idle dbg_state", 32'(dbg_state), 32'd0);

    // Full frame, back-to-back beats, no in_last
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("full pre8 out_valid", 32'(out_valid), 32'd0);
      send_word(words8[i], 1'b0);
    end
    check("full dbg_state", 32'(dbg_state), 32'd1);
    check_frame("full8", 4'd8, 7'h00);
    release_frame("full8 rel");

    // Two-word frame with hold under back-pressure and stray input
    send_word(7'h55, 1'b0);
    send_word(7'h54, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = i[0];
      in_data  = 7'(i * 13);
      tick();
      check($sformatf("hold%0d a", i), 32'(a), 32'h55);
      check($sformatf("hold%0d b", i), 32'(b), 32'h54);
      check($sformatf("hold%0d c", i), 32'(c), 32'(ONES));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_frame("short2", 4'd2, 7'h54);
    release_frame("short2 rel");

    // Idle gaps with in_last and out_ready asserted but no beat
    in_last   = 1'b1;
    out_ready = 1'b1;
    in_data   = 7'h11;
    tick();
    tick();
    in_last   = 1'b0;
    out_ready = 1'b0;
    check_empty("gap");
    send_word(7'h2A, 1'b1);
    check_frame("single", 4'd1, 7'h2A);
    release_frame("single rel");

    // in_last on the 8th word behaves like a plain 8th word
    for (int i = 0; i < 8; i++) send_word(7'(7'h40 | i), i == 7);
    check_frame("last8", 4'd8, 7'h40);
    release_frame("last8 rel");

    // Reset after four words; outputs clear without a clock edge
    for (int i = 0; i < 4; i++) send_word(7'(i + 1), 1'b0);
    check("mid n_words", 32'(n_words), 32'd4);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_empty("async rst");
    tick();
    reset = 1'b0;
    tick();
    send_word(7'h33, 1'b1);
    check_frame("post rst", 4'd1, 7'h33);
    release_frame("post rst rel");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
